// File: rtl/dag_pkg.sv
// Shared encodings and register-file address field helpers for the circular data address generator.
package dag_pkg;

  typedef enum logic [1:0] {
    REG_I = 2'b00,
    REG_M = 2'b01,
    REG_L = 2'b10,
    REG_B = 2'b11
  } reg_type_e;

  typedef enum logic {
    DAG_DM = 1'b0,
    DAG_PS = 1'b1
  } dag_sel_e;

  localparam int NUM_DAG = 2;

  // Register-file addresses are {type[1:0], dag, idx[iw-1:0]}; callers zero-extend to 32 bits.
  function automatic reg_type_e addr_type(input logic [31:0] a, input int iw);
    return reg_type_e'(a[iw+1 +: 2]);
  endfunction

  function automatic logic addr_dag(input logic [31:0] a, input int iw);
    return a[iw];
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int iw);
    return a & ((32'd1 << iw) - 32'd1);
  endfunction

endpackage

// File: rtl/dag_circ_wrap.sv
// Per-half address arithmetic: index+modifier sum, circular-buffer wrap and bit-reversed post address.
module dag_circ_wrap #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] ib,
  input  logic [AW-1:0] mod,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          brev,
  output logic [AW-1:0] sum,
  output logic [AW-1:0] wrapped,
  output logic [AW-1:0] post_addr
);

  logic [AW:0]   x;
  logic [AW:0]   lim;
  logic [AW-1:0] rev;

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    sum     = ib + mod;
    x       = {1'b0, sum};
    lim     = {1'b0, base} + {1'b0, len};
    wrapped = sum;
    // The truncated sum is compared one bit wider so B+L never overflows.
    if (len != '0) begin
      if (x >= lim) begin
        wrapped = AW'(x - {1'b0, len});
      end else if (x < {1'b0, base}) begin
        wrapped = AW'(x + {1'b0, len});
      end
    end
  end

  always_comb begin
    rev = '0;
    for (int k = 0; k < AW; k++) begin
      rev[k] = ib[AW-1-k];
    end
    post_addr = brev ? rev : ib;
  end

endmodule

// File: rtl/dag_circ.sv
// Dual-half data address generator with circular wrap, bit reversal, immediate modify and registered outputs.
module dag_circ
  import dag_pkg::*;
#(
  parameter  int AW   = 16,
  parameter  int NREG = 8,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk_rf,
  input  logic          rst_rf_n,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic          ps_dg_brev,
  input  logic          ps_dmiaddinst,
  input  logic [IW-1:0] ps_dg_iadd,
  input  logic [IW-1:0] ps_dg_madd,
  input  logic [AW-1:0] ps_dg_immdt,
  input  logic          ps_dg_wrt_en,
  input  logic [IW+2:0] ps_dg_wrt_add,
  input  logic [IW+2:0] ps_dg_rd_add,
  input  logic [AW-1:0] bc_dt,
  output logic [AW-1:0] dg_dm_add,
  output logic [AW-1:0] dg_ps_add,
  output logic          dg_add_vld,
  output logic [AW-1:0] dg_bc_dt
);

  logic [AW-1:0] i_q [NUM_DAG][NREG];
  logic [AW-1:0] m_q [NUM_DAG][NREG];
  logic [AW-1:0] l_q [NUM_DAG][NREG];
  logic [AW-1:0] b_q [NUM_DAG][NREG];

  reg_type_e     wr_type;
  reg_type_e     rd_type;
  logic          wr_dag;
  logic          rd_dag;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  dag_sel_e      sel;

  assign wr_type = addr_type(32'(ps_dg_wrt_add), IW);
  assign wr_dag  = addr_dag(32'(ps_dg_wrt_add), IW);
  assign wr_idx  = IW'(addr_idx(32'(ps_dg_wrt_add), IW));
  assign rd_type = addr_type(32'(ps_dg_rd_add), IW);
  assign rd_dag  = addr_dag(32'(ps_dg_rd_add), IW);
  assign rd_idx  = IW'(addr_idx(32'(ps_dg_rd_add), IW));
  assign sel     = dag_sel_e'(ps_dg_dgsclt);

  logic [AW-1:0] ib   [NUM_DAG];
  logic [AW-1:0] mod  [NUM_DAG];
  logic [AW-1:0] sum  [NUM_DAG];
  logic [AW-1:0] nxt  [NUM_DAG];
  logic [AW-1:0] post [NUM_DAG];

  // Both halves compute in parallel; only the selected one is used.
  for (genvar h = 0; h < NUM_DAG; h++) begin : g_half
    logic i_byp;
    logic m_byp;

    always_comb begin
      i_byp = ps_dg_wrt_en && (wr_type == REG_I) && (wr_dag == 1'(h)) && (wr_idx == ps_dg_iadd);
      m_byp = ps_dg_wrt_en && (wr_type == REG_M) && (wr_dag == 1'(h)) && (wr_idx == ps_dg_madd);
    end

    assign ib[h]  = i_byp ? bc_dt : i_q[h][ps_dg_iadd];
    assign mod[h] = ps_dmiaddinst ? ps_dg_immdt : (m_byp ? bc_dt : m_q[h][ps_dg_madd]);

    dag_circ_wrap #(.AW(AW)) u_wrap (
      .ib        (ib[h]),
      .mod       (mod[h]),
      .base      (b_q[h][ps_dg_iadd]),
      .len       (l_q[h][ps_dg_iadd]),
      .brev      (ps_dg_brev),
      .sum       (sum[h]),
      .wrapped   (nxt[h]),
      .post_addr (post[h])
    );
  end

  logic [AW-1:0] addr_sel;
  logic          post_mod;
  logic          pm_hit;
  logic [AW-1:0] rd_reg;

  always_comb begin
    post_mod = ps_dg_en && !ps_dg_mdfy;
    addr_sel = ps_dg_mdfy ? sum[sel] : post[sel];
    // A plain I write loses to a post-modify of the same I, whose sum already used bc_dt.
    pm_hit   = post_mod && (wr_dag == ps_dg_dgsclt) && (wr_idx == ps_dg_iadd);
  end

  always_comb begin
    rd_reg = '0;
    unique case (rd_type)
      REG_I: rd_reg = i_q[rd_dag][rd_idx];
      REG_M: rd_reg = m_q[rd_dag][rd_idx];
      REG_L: rd_reg = l_q[rd_dag][rd_idx];
      REG_B: rd_reg = b_q[rd_dag][rd_idx];
    endcase
    dg_bc_dt = (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) ? bc_dt : rd_reg;
  end

  // NOTE: the register file is reset explicitly because software relies on all-zero L (linear mode) after reset.
  always_ff @(posedge clk_rf or negedge rst_rf_n) begin
    if (!rst_rf_n) begin
      for (int d = 0; d < NUM_DAG; d++) begin
        for (int r = 0; r < NREG; r++) begin
          i_q[d][r] <= '0;
          m_q[d][r] <= '0;
          l_q[d][r] <= '0;
          b_q[d][r] <= '0;
        end
      end
    end else begin
      if (post_mod) begin
        i_q[sel][ps_dg_iadd] <= nxt[sel];
      end
      // A B write is ordered last so its I reload overrides a same-cycle post-modify.
      if (ps_dg_wrt_en) begin
        unique case (wr_type)
          REG_I: if (!pm_hit) i_q[wr_dag][wr_idx] <= bc_dt;
          REG_M: m_q[wr_dag][wr_idx] <= bc_dt;
          REG_L: l_q[wr_dag][wr_idx] <= bc_dt;
          REG_B: begin
            b_q[wr_dag][wr_idx] <= bc_dt;
            i_q[wr_dag][wr_idx] <= bc_dt;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_rf or negedge rst_rf_n) begin
    if (!rst_rf_n) begin
      dg_dm_add  <= '0;
      dg_ps_add  <= '0;
      dg_add_vld <= 1'b0;
    end else begin
      dg_dm_add  <= (ps_dg_en && sel == DAG_DM) ? addr_sel : '0;
      dg_ps_add  <= (ps_dg_en && sel == DAG_PS) ? addr_sel : '0;
      dg_add_vld <= ps_dg_en;
    end
  end

endmodule
